// File: rtl/scan_tail_checker.sv
// Scan-chain tail checker: measures chain length from arm to the head pulse
// arriving at SC_TAIL, then checks pulse width and post-pulse quiet period.
module scan_tail_checker #(
    parameter int LEN_WIDTH     = 16,
    parameter int MAX_SAMPLES   = 4096,
    parameter int PULSE_WIDTH   = 2,
    parameter int QUIET_SAMPLES = 64,
    parameter int ERR_WIDTH     = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic                 start,
    input  logic                 sc_tail,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [LEN_WIDTH-1:0] chain_len,
    output logic [ERR_WIDTH-1:0] err_count
);

    localparam int PW_W = $clog2(PULSE_WIDTH + 1);
    localparam int QW   = $clog2(QUIET_SAMPLES + 1);

    localparam logic [LEN_WIDTH-1:0] MAX_CNT = LEN_WIDTH'(MAX_SAMPLES);
    localparam logic [PW_W-1:0]      PW_END  = PW_W'(PULSE_WIDTH);
    localparam logic [QW-1:0]        Q_LAST  = QW'(QUIET_SAMPLES - 1);
    localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TAIL,
        CHECK,
        DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tail_s;
    logic [LEN_WIDTH-1:0]   cnt;
    logic [LEN_WIDTH-1:0]   cnt_inc;
    logic [PW_W-1:0]        pw_cnt;
    logic [QW-1:0]          quiet_cnt;
    logic                   in_phase_a;
    logic                   mismatch;
    logic [ERR_WIDTH-1:0]   err_next;

    // NOTE: synchronizer flops are reset too, so a stale pad level captured
    // before reset can never be sampled as the first tail value of a run.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sc_tail};
        end
    end

    assign tail_s = sync_q[SYNC_STAGES-1];

    // NOTE: every signal driven here gets a value on every path, so no latches.
    always_comb begin
        cnt_inc    = cnt + 1'b1;
        in_phase_a = (pw_cnt < PW_END);
        mismatch   = (state == CHECK) && sample_en && (in_phase_a ? !tail_s : tail_s);
        err_next   = (mismatch && (err_count != ERR_MAX)) ? err_count + 1'b1 : err_count;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below reads the pre-edge values of cnt, pw_cnt and err_count.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            pw_cnt    <= '0;
            quiet_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            chain_len <= '0;
            err_count <= '0;
        end else begin
            case (state)
                // Arming from IDLE or DONE is identical; a coincident sample is not counted.
                IDLE, DONE: begin
                    if (start) begin
                        state     <= WAIT_TAIL;
                        cnt       <= '0;
                        pw_cnt    <= '0;
                        quiet_cnt <= '0;
                        chain_len <= '0;
                        err_count <= '0;
                        timeout   <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end

                WAIT_TAIL: begin
                    if (sample_en) begin
                        cnt <= cnt_inc;
                        if (tail_s) begin
                            chain_len <= cnt_inc;
                            pw_cnt    <= PW_W'(1);
                            quiet_cnt <= '0;
                            state     <= CHECK;
                        end else if (cnt_inc == MAX_CNT) begin
                            chain_len <= MAX_CNT;
                            timeout   <= 1'b1;
                            pass      <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                CHECK: begin
                    if (sample_en) begin
                        err_count <= err_next;
                        if (in_phase_a) begin
                            pw_cnt <= pw_cnt + 1'b1;
                        end else if (quiet_cnt == Q_LAST) begin
                            pass  <= (err_next == '0);
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            quiet_cnt <= quiet_cnt + 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
